// File: rtl/temp_log_buffer_pkg.sv
// Record layout and statistics constants shared by the temperature log buffer.
package temp_log_buffer_pkg;

   localparam int RECORD_W = 34;

   localparam int TEMP_LSB = 0;
   localparam int SEC_LSB  = 8;
   localparam int MIN_LSB  = 14;
   localparam int HR_LSB   = 20;
   localparam int DAY_LSB  = 25;
   localparam int MON_LSB  = 30;

   localparam logic [7:0] MIN_INIT = 8'hFF;
   localparam logic [7:0] MAX_INIT = 8'h00;

   typedef logic [RECORD_W-1:0] record_t;

   function automatic record_t pack_record(
      input logic [7:0] temp,
      input logic [5:0] sec,
      input logic [5:0] mins,
      input logic [4:0] hrs,
      input logic [4:0] day,
      input logic [3:0] mon
   );
      record_t r;
      r                 = '0;
      r[TEMP_LSB +: 8]  = temp;
      r[SEC_LSB  +: 6]  = sec;
      r[MIN_LSB  +: 6]  = mins;
      r[HR_LSB   +: 5]  = hrs;
      r[DAY_LSB  +: 5]  = day;
      r[MON_LSB  +: 4]  = mon;
      return r;
   endfunction

endpackage

// File: rtl/temp_log_buffer_ram.sv
// Simple dual-port record store: synchronous write, registered read with enable.
module temp_log_buffer_ram #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int DATA_W = 34
) (
   input  logic              clk,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_rd_en,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // NOTE: no reset on the array or read register; the top never exposes a
   // location that was not written since reset, so a reset would only cost logic.
   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
      if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
   end

endmodule

// File: rtl/temp_log_buffer.sv
// Timestamped circular log of received temperature bytes with running min/max.
module temp_log_buffer
   import temp_log_buffer_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int ADDR_W    = 4,
   parameter bit OVERWRITE = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [7:0]          rx_data,
   input  logic                rx_valid,
   input  logic [5:0]          seconds,
   input  logic [5:0]          minutes,
   input  logic [4:0]          hours,
   input  logic [4:0]          days,
   input  logic [3:0]          months,
   input  logic                rd_en,
   input  logic                clear_stats,
   output logic [RECORD_W-1:0] rd_data,
   output logic                rd_valid,
   output logic                empty,
   output logic                full,
   output logic [ADDR_W:0]     count,
   output logic                overflow,
   output logic [7:0]          min_temp,
   output logic [7:0]          max_temp
);

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic              r_rd_valid, r_has_data, r_overflow;
   logic [7:0]        r_min, r_max;

   logic    w_full, w_empty, w_rd_fire, w_wr_fire, w_lost, w_drop_oldest;
   record_t w_record, w_ram_q;

   assign w_full        = (r_count == FULL_CNT);
   assign w_empty       = (r_count == '0);
   assign w_rd_fire     = rd_en && !w_empty;
   // A full buffer with no concurrent pop cannot absorb the sample as-is.
   assign w_lost        = rx_valid && w_full && !w_rd_fire;
   assign w_drop_oldest = w_lost && OVERWRITE;
   assign w_wr_fire     = rx_valid && (!w_lost || OVERWRITE);
   assign w_record      = pack_record(rx_data, seconds, minutes, hours, days, months);

   temp_log_buffer_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (RECORD_W)
   ) u_ram (
      .clk       (clk),
      .i_wr_en   (w_wr_fire),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (w_record),
      .i_rd_en   (w_rd_fire),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (w_ram_q)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_rd_valid <= 1'b0;
         r_has_data <= 1'b0;
      end else begin
         if (w_wr_fire)                  r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_fire || w_drop_oldest) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_wr_fire && !w_rd_fire && !w_full)
            r_count <= r_count + 1'b1;
         else if (w_rd_fire && !w_wr_fire)
            r_count <= r_count - 1'b1;
         r_rd_valid <= w_rd_fire;
         if (w_rd_fire) r_has_data <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_min      <= MIN_INIT;
         r_max      <= MAX_INIT;
         r_overflow <= 1'b0;
      end else if (clear_stats) begin
         r_min      <= w_wr_fire ? rx_data : MIN_INIT;
         r_max      <= w_wr_fire ? rx_data : MAX_INIT;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr_fire && (rx_data < r_min)) r_min <= rx_data;
         if (w_wr_fire && (rx_data > r_max)) r_max <= rx_data;
         if (w_lost) r_overflow <= 1'b1;
      end
   end

   // The RAM read register is unreset, so mask it until the first real pop.
   assign rd_data  = r_has_data ? w_ram_q : '0;
   assign rd_valid = r_rd_valid;
   assign empty    = w_empty;
   assign full     = w_full;
   assign count    = r_count;
   assign overflow = r_overflow;
   assign min_temp = r_min;
   assign max_temp = r_max;

endmodule

// File: tb/tb_temp_log_buffer.sv
// Scoreboard bench: one overwrite and one drop-mode buffer share random stimulus.
module tb_temp_log_buffer;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   typedef struct {
      logic [33:0] rec;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic [5:0]  seconds = '0;
   logic [5:0]  minutes = '0;
   logic [4:0]  hours = '0;
   logic [4:0]  days = '0;
   logic [3:0]  months = '0;
   logic        rd_en = 1'b0;
   logic        clear_stats = 1'b0;

   logic [33:0]     rd_data  [2];
   logic            rd_valid [2];
   logic            empty    [2];
   logic            full     [2];
   logic [ADDR_W:0] count    [2];
   logic            overflow [2];
   logic [7:0]      min_temp [2];
   logic [7:0]      max_temp [2];

   // Index 0 overwrites the oldest record when full, index 1 drops the new one.
   logic [33:0] m_q  [2][$];
   exp_t        sb_q [2][$];
   logic [7:0]  m_min [2];
   logic [7:0]  m_max [2];
   logic        m_ovf [2];
   logic [33:0] m_hold [2];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   temp_log_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .OVERWRITE(1'b1)) u_dut_ow (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .seconds(seconds), .minutes(minutes), .hours(hours), .days(days), .months(months),
      .rd_en(rd_en), .clear_stats(clear_stats),
      .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .empty(empty[0]), .full(full[0]),
      .count(count[0]), .overflow(overflow[0]), .min_temp(min_temp[0]), .max_temp(max_temp[0])
   );

   temp_log_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .OVERWRITE(1'b0)) u_dut_dr (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .seconds(seconds), .minutes(minutes), .hours(hours), .days(days), .months(months),
      .rd_en(rd_en), .clear_stats(clear_stats),
      .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .empty(empty[1]), .full(full[1]),
      .count(count[1]), .overflow(overflow[1]), .min_temp(min_temp[1]), .max_temp(max_temp[1])
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_q[m].delete();
         sb_q[m].delete();
         m_min[m]  = 8'hFF;
         m_max[m]  = 8'h00;
         m_ovf[m]  = 1'b0;
         m_hold[m] = '0;
      end
   endtask

   // Behavioural reference: a FIFO of records plus min/max/overflow rules.
   task automatic model_step(input int m, input bit wr, input logic [33:0] rec,
                             input bit rd, input bit clr);
      int          n;
      bit          rd_ok, acc;
      logic [33:0] tmp;
      exp_t        e;
      n     = m_q[m].size();
      rd_ok = rd && (n > 0);
      if (rd_ok) begin
         m_hold[m] = m_q[m].pop_front();
         e.rec = m_hold[m];
         e.cyc = cyc + 1;
         sb_q[m].push_back(e);
      end
      acc = wr && ((n < DEPTH) || rd_ok || (m == 0));
      if (wr && (n == DEPTH) && !rd_ok) begin
         m_ovf[m] = 1'b1;
         if (m == 0) tmp = m_q[m].pop_front();
      end
      if (acc) m_q[m].push_back(rec);
      if (clr) begin
         m_ovf[m] = 1'b0;
         m_min[m] = acc ? rec[7:0] : 8'hFF;
         m_max[m] = acc ? rec[7:0] : 8'h00;
      end else if (acc) begin
         if (rec[7:0] < m_min[m]) m_min[m] = rec[7:0];
         if (rec[7:0] > m_max[m]) m_max[m] = rec[7:0];
      end
   endtask

   // One call per clock: inputs change just after the falling edge.
   task automatic drive(input bit wr, input logic [7:0] d, input bit rd, input bit clr,
                        input logic [25:0] ts);
      @(negedge clk);
      #1;
      rx_valid    = wr;
      rx_data     = d;
      rd_en       = rd;
      clear_stats = clr;
      {months, days, hours, minutes, seconds} = ts;
      for (int m = 0; m < 2; m++) model_step(m, wr, {ts, d}, rd, clr);
   endtask

   function automatic logic [25:0] rand_ts();
      return {4'($urandom_range(1, 12)), 5'($urandom_range(1, 31)), 5'($urandom_range(0, 23)),
              6'($urandom_range(0, 59)), 6'($urandom_range(0, 59))};
   endfunction

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 8'h00, 1'b0, 1'b0, rand_ts());
   endtask

   task automatic pop(input int n);
      repeat (n) drive(1'b0, 8'h00, 1'b1, 1'b0, rand_ts());
   endtask

   // Monitor: pops the scoreboard on every rd_valid and compares status each cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         for (int m = 0; m < 2; m++) begin
            if (rd_valid[m]) begin
               if (sb_q[m].size() == 0) begin
                  check($sformatf("rd_valid_unexpected[%0d]", m), 64'(rd_valid[m]), 64'd0);
               end else begin
                  e = sb_q[m].pop_front();
                  check($sformatf("pop_record[%0d]", m), 64'(rd_data[m]), 64'(e.rec));
                  check($sformatf("pop_latency_cycle[%0d]", m), 64'(cyc), 64'(e.cyc));
               end
            end
            check($sformatf("rd_data_hold[%0d]", m), 64'(rd_data[m]), 64'(m_hold[m]));
            check($sformatf("count[%0d]", m), 64'(count[m]), 64'(m_q[m].size()));
            check($sformatf("empty[%0d]", m), 64'(empty[m]), 64'(m_q[m].size() == 0));
            check($sformatf("full[%0d]", m), 64'(full[m]), 64'(m_q[m].size() == DEPTH));
            check($sformatf("overflow[%0d]", m), 64'(overflow[m]), 64'(m_ovf[m]));
            check($sformatf("min_temp[%0d]", m), 64'(min_temp[m]), 64'(m_min[m]));
            check($sformatf("max_temp[%0d]", m), 64'(max_temp[m]), 64'(m_max[m]));
         end
      end
   end

   initial begin
      logic [25:0] ts_fix;
      ts_fix = {4'd3, 5'd12, 5'd7, 6'd45, 6'd9};
      model_reset();
      @(negedge clk);
      #1;
      reset = 1'b0;

      // Basic ordered writes and pops with a fixed timestamp.
      drive(1'b1, 8'h20, 1'b0, 1'b0, ts_fix);
      drive(1'b1, 8'h35, 1'b0, 1'b0, ts_fix);
      drive(1'b1, 8'h10, 1'b0, 1'b0, ts_fix);
      idle(1);
      pop(3);
      idle(1);
      pop(2);
      idle(1);

      // Fill past capacity: 17 samples 0..16, then drain fully.
      for (int i = 0; i <= 16; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, rand_ts());
      idle(1);
      pop(17);
      idle(1);

      // Full buffer with simultaneous write and pop.
      drive(1'b0, 8'h00, 1'b0, 1'b1, rand_ts());
      for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'($urandom_range(0, 120)), 1'b0, 1'b0, rand_ts());
      drive(1'b1, 8'h7F, 1'b1, 1'b0, rand_ts());
      idle(1);
      pop(17);
      idle(1);

      // Clear with a coincident sample.
      drive(1'b1, 8'h42, 1'b0, 1'b1, rand_ts());
      idle(1);
      pop(2);

      // Asynchronous reset while a pop is being presented.
      for (int i = 0; i < 6; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0, rand_ts());
      pop(1);
      @(negedge clk);
      #2;
      reset       = 1'b1;
      rx_valid    = 1'b0;
      rd_en       = 1'b0;
      clear_stats = 1'b0;
      #1;
      for (int m = 0; m < 2; m++) begin
         check($sformatf("async_rd_valid[%0d]", m), 64'(rd_valid[m]), 64'd0);
         check($sformatf("async_rd_data[%0d]", m), 64'(rd_data[m]), 64'd0);
         check($sformatf("async_count[%0d]", m), 64'(count[m]), 64'd0);
         check($sformatf("async_empty[%0d]", m), 64'(empty[m]), 64'd1);
         check($sformatf("async_min[%0d]", m), 64'(min_temp[m]), 64'hFF);
         check($sformatf("async_max[%0d]", m), 64'(max_temp[m]), 64'h00);
      end
      model_reset();
      @(negedge clk);
      #1;
      reset = 1'b0;
      drive(1'b1, 8'h55, 1'b0, 1'b0, rand_ts());
      pop(2);
      idle(1);

      // Random traffic, biased toward writes so both full policies are exercised.
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 40,
               $urandom_range(0, 99) < 4, rand_ts());
      end
      pop(DEPTH + 2);
      idle(2);

      for (int m = 0; m < 2; m++)
         check($sformatf("scoreboard_drained[%0d]", m), 64'(sb_q[m].size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
